// File: rtl/serial_add_sequencer_pkg.sv
// rtl/serial_add_sequencer_pkg.sv - shared state encoding for the bit-serial adder
package serial_add_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_sequencer_cell.sv
// rtl/serial_add_sequencer_cell.sv - one-bit full adder built from two half adders
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p, g, pc;

  half_adder u_ha0 (.x(a), .y(b),   .s(p), .c(g));
  half_adder u_ha1 (.x(p), .y(cin), .s(s), .c(pc));

  assign cout = g | pc;

endmodule

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial WIDTH-bit adder with start/busy/done handshake
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] sum_next;

  full_adder_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // New bit enters at the MSB so the LSB-first result lands in place after WIDTH shifts.
  always_comb begin
    sum_next            = sum >> 1;
    sum_next[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      count <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sum   <= sum_next;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_c;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            cout  <= fa_c;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - self-checking bench for serial_add_sequencer at WIDTH 1, 8 and 13
module tb_serial_add_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_req = 1'b0;
  int          sel = 8;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  logic        busy1, done1, cout1;
  logic [0:0]  sum1;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        busy13, done13, cout13;
  logic [12:0] sum13;

  serial_add_sequencer #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_req && sel == 1), .a(opa[0:0]), .b(opb[0:0]),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );
  serial_add_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_req && sel == 8), .a(opa[7:0]), .b(opb[7:0]),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_add_sequencer #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start_req && sel == 13), .a(opa[12:0]), .b(opb[12:0]),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
  );

  logic        cur_busy, cur_done, cur_cout;
  logic [31:0] cur_sum;

  always_comb begin
    cur_busy = 1'b0;
    cur_done = 1'b0;
    cur_cout = 1'b0;
    cur_sum  = '0;
    case (sel)
      1:  begin cur_busy = busy1;  cur_done = done1;  cur_cout = cout1;  cur_sum = {31'b0, sum1};  end
      8:  begin cur_busy = busy8;  cur_done = done8;  cur_cout = cout8;  cur_sum = {24'b0, sum8};  end
      13: begin cur_busy = busy13; cur_done = done13; cur_cout = cout13; cur_sum = {19'b0, sum13}; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (w=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  // One add on the selected instance; optional mid-op operand change, ignored start pokes, or reset abort.
  task automatic op(input int w, input logic [31:0] av, input logic [31:0] bv,
                    input bit chg, input bit poke, input int rst_at);
    logic [31:0] m;
    logic [32:0] full;
    int          n;
    bit          seen;
    m    = (32'd1 << w) - 32'd1;
    full = {1'b0, av & m} + {1'b0, bv & m};
    sel  = w;
    @(negedge clk);
    opa = av;
    opb = bv;
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    n = 1;
    seen = 1'b0;
    while (n <= w + 10) begin
      if (rst_at != 0 && n == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(cur_busy), 32'd0);
        check("abort_done", 32'(cur_done), 32'd0);
        check("abort_sum",  cur_sum, 32'd0);
        check("abort_cout", 32'(cur_cout), 32'd0);
        return;
      end
      if (chg && n == 2) begin
        opa = '1;
        opb = '1;
      end
      start_req = poke && (n == 3 || n == 9);
      if (cur_done) begin
        seen = 1'b1;
        break;
      end
      check("busy_during", 32'(cur_busy), 32'd1);
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", n, w + 1);
      check("sum",  cur_sum, full[31:0] & m);
      check("cout", 32'(cur_cout), 32'(full[w]));
      check("busy_at_done", 32'(cur_busy), 32'd1);
      @(negedge clk);
      start_req = 1'b0;
      check("done_pulse", 32'(cur_done), 32'd0);
      check("busy_after", 32'(cur_busy), 32'd0);
      check("sum_hold", cur_sum, full[31:0] & m);
    end
  endtask

  task automatic held_start();
    int dn[$];
    sel = 8;
    @(negedge clk);
    opa = 32'h21;
    opb = 32'h43;
    start_req = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 30) start_req = 1'b0;
      if (cur_done) begin
        dn.push_back(c);
        check("held_sum", cur_sum, 32'h64);
      end
    end
    check("held_count", dn.size(), 3);
    if (dn.size() == 3) begin
      check("held_first", dn[0], 9);
      check("held_gap0", dn[1] - dn[0], 10);
      check("held_gap1", dn[2] - dn[1], 10);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = (k == 0) ? 1 : (k == 1) ? 8 : 13;
      #1;
      check("rst_busy", 32'(cur_busy), 32'd0);
      check("rst_done", 32'(cur_done), 32'd0);
      check("rst_sum",  cur_sum, 32'd0);
      check("rst_cout", 32'(cur_cout), 32'd0);
    end
    rst = 1'b0;

    op(8, 32'h3C, 32'h5A, 1'b0, 1'b1, 0);
    op(8, 32'hFF, 32'h01, 1'b0, 1'b0, 0);
    op(8, 32'h80, 32'h80, 1'b0, 1'b0, 0);
    op(8, 32'h00, 32'h00, 1'b0, 1'b0, 0);
    held_start();
    op(8, 32'h12, 32'h34, 1'b1, 1'b0, 0);
    op(8, 32'h55, 32'hAA, 1'b0, 1'b0, 4);
    op(8, 32'h77, 32'h99, 1'b0, 1'b0, 0);
    for (int k = 0; k < 4; k++) op(1, 32'(k & 1), 32'(k >> 1), 1'b0, 1'b0, 0);
    repeat (500) op(8,  $urandom, $urandom, 1'b0, 1'b0, 0);
    repeat (500) op(13, $urandom, $urandom, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
